// File: rtl/bmr_tdee_qsys_nios2_dbg_cmd_bridge_pkg.sv
// Shared defaults and instruction encodings for the Nios II debug command bridge.
package bmr_tdee_nios2_dbg_pkg;

    localparam int DEFAULT_IR_W        = 2;
    localparam int DEFAULT_DR_W        = 38;
    localparam int DEFAULT_DEPTH       = 4;
    localparam int DEFAULT_SYNC_STAGES = 2;

    // Instruction encodings of the default 2-bit IR configuration
    typedef enum logic [1:0] {
        IR_OCIMEM    = 2'd0,
        IR_TRACEMEM  = 2'd1,
        IR_BREAK     = 2'd2,
        IR_TRACECTRL = 2'd3
    } dbg_ir_e;

endpackage

// File: rtl/bmr_tdee_qsys_nios2_dbg_cmd_bridge_if.sv
// Command handshake between the bridge (master) and the debug logic consuming commands (slave).
interface bmr_tdee_qsys_nios2_dbg_cmd_bridge_if
    import bmr_tdee_nios2_dbg_pkg::*;
#(
    parameter int IR_W = DEFAULT_IR_W,
    parameter int DR_W = DEFAULT_DR_W
);
    localparam int NUM_CMD = 2 ** IR_W;

    logic                cmd_valid;
    logic                cmd_ready;
    logic [IR_W-1:0]     cmd_ir;
    logic [DR_W-1:0]     jdo;
    logic [NUM_CMD-1:0]  take_action;
    logic [NUM_CMD-1:0]  take_no_action;

    modport master (
        output cmd_valid,
        input  cmd_ready,
        output cmd_ir,
        output jdo,
        output take_action,
        output take_no_action
    );

    modport slave (
        input  cmd_valid,
        output cmd_ready,
        input  cmd_ir,
        input  jdo,
        input  take_action,
        input  take_no_action
    );

endinterface

// File: rtl/bmr_tdee_qsys_nios2_dbg_cmd_bridge_sync_edge.sv
// Brings an asynchronous TCK-domain strobe into clk and emits a registered one-cycle pulse per rise.
module bmr_tdee_nios2_dbg_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic strobe_i,
    output logic rise_o
);
    localparam int LAST = SYNC_STAGES - 1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] vld_q;
    logic                   hist_q;
    logic                   armed_q;
    logic                   armed_d;
    logic                   rise_q;
    logic                   rise_d;

    // A rise only counts once a genuine post-reset low has reached the last stage, so a strobe
    // that is already high when reset releases cannot fake an edge against the cleared history.
    always_comb begin
        armed_d = armed_q | (vld_q[LAST] & ~sync_q[LAST]);
        rise_d  = sync_q[LAST] & ~hist_q & armed_q;
    end

    // Synchroniser chain, fill tracker, history flop and registered rise pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            vld_q   <= '0;
            hist_q  <= 1'b0;
            armed_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], strobe_i};
            vld_q   <= {vld_q[SYNC_STAGES-2:0], 1'b1};
            hist_q  <= sync_q[LAST];
            armed_q <= armed_d;
            rise_q  <= rise_d;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/bmr_tdee_qsys_nios2_dbg_cmd_bridge.sv
// System-clock side of the Nios II JTAG debug path: queues captured {ir, sr} commands and
// presents them one at a time, decoding each pop into one-hot action / no-action pulses.
module bmr_tdee_qsys_nios2_dbg_cmd_bridge
    import bmr_tdee_nios2_dbg_pkg::*;
#(
    parameter int IR_W        = DEFAULT_IR_W,
    parameter int DR_W        = DEFAULT_DR_W,
    parameter int DEPTH       = DEFAULT_DEPTH,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter int ACTION_BIT  = DR_W - 1,
    localparam int NUM_CMD    = 2 ** IR_W,
    localparam int LVL_W      = $clog2(DEPTH + 1),
    localparam int PTR_W      = $clog2(DEPTH)
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  vs_udr_i,
    input  logic                                  vs_uir_i,
    input  logic [IR_W-1:0]                       ir_in_i,
    input  logic [DR_W-1:0]                       sr_i,
    bmr_tdee_qsys_nios2_dbg_cmd_bridge_if.master  cmd,
    output logic                                  ir_update_o,
    output logic [LVL_W-1:0]                      fifo_level_o,
    output logic                                  overflow_o,
    input  logic                                  ovf_clr_i
);

    logic                udr_rise;
    logic                uir_rise;

    logic [IR_W-1:0]     mem_ir_q [DEPTH];
    logic [DR_W-1:0]     mem_dr_q [DEPTH];

    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic                ovf_q, ovf_d;
    logic [DR_W-1:0]     jdo_q, jdo_d;
    logic [NUM_CMD-1:0]  act_q, act_d;
    logic [NUM_CMD-1:0]  noact_q, noact_d;

    logic                full;
    logic                not_empty;
    logic                pop;
    logic                push_ok;
    logic                drop;
    logic [IR_W-1:0]     head_ir;
    logic [DR_W-1:0]     head_dr;

    bmr_tdee_nios2_dbg_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_udr_sync (
        .clk      (clk),
        .reset    (reset),
        .strobe_i (vs_udr_i),
        .rise_o   (udr_rise)
    );

    bmr_tdee_nios2_dbg_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_uir_sync (
        .clk      (clk),
        .reset    (reset),
        .strobe_i (vs_uir_i),
        .rise_o   (uir_rise)
    );

    // Handshake qualification: a pop at full frees the slot the same-cycle push lands in
    always_comb begin
        full      = (level_q == LVL_W'(DEPTH));
        not_empty = (level_q != '0);
        pop       = not_empty & cmd.cmd_ready;
        push_ok   = udr_rise & (~full | pop);
        drop      = udr_rise & full & ~pop;
        head_ir   = mem_ir_q[rd_ptr_q];
        head_dr   = mem_dr_q[rd_ptr_q];
    end

    // Next-state for pointers, occupancy, sticky overflow and the popped-command outputs
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        level_d  = level_q + LVL_W'(push_ok) - LVL_W'(pop);
        ovf_d    = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr_i) begin
            ovf_d = 1'b0;
        end
        jdo_d   = jdo_q;
        act_d   = '0;
        noact_d = '0;
        if (pop) begin
            jdo_d = head_dr;
            if (head_dr[ACTION_BIT]) begin
                act_d[head_ir] = 1'b1;
            end else begin
                noact_d[head_ir] = 1'b1;
            end
        end
    end

    // Control and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            jdo_q    <= '0;
            act_q    <= '0;
            noact_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            jdo_q    <= jdo_d;
            act_q    <= act_d;
            noact_q  <= noact_d;
        end
    end

    // Command storage needs no reset: entries are only read while the level covers them
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_ir_q[wr_ptr_q] <= ir_in_i;
            mem_dr_q[wr_ptr_q] <= sr_i;
        end
    end

    assign cmd.cmd_valid      = not_empty;
    assign cmd.cmd_ir         = not_empty ? head_ir : '0;
    assign cmd.jdo            = jdo_q;
    assign cmd.take_action    = act_q;
    assign cmd.take_no_action = noact_q;
    assign ir_update_o        = uir_rise;
    assign fifo_level_o       = level_q;
    assign overflow_o         = ovf_q;

endmodule

// File: tb/tb_bmr_tdee_qsys_nios2_dbg_cmd_bridge.sv
// Self-checking bench for the debug command bridge: a queue-based model predicts every output
// each cycle, and directed sequences pin the model with hand-computed literal values.
module tb_bmr_tdee_qsys_nios2_dbg_cmd_bridge;
   import bmr_tdee_nios2_dbg_pkg::*;

   localparam int IR_W        = 2;
   localparam int DR_W        = 38;
   localparam int DEPTH       = 4;
   localparam int SYNC_STAGES = 2;
   localparam int ACTION_BIT  = DR_W - 1;
   localparam int NUM_CMD     = 4;
   localparam int LVL_W       = 3;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic vsUdr = 1'b0;
   logic vsUir = 1'b0;
   logic ovfClr = 1'b0;
   logic [IR_W-1:0] irIn = '0;
   logic [DR_W-1:0] srIn = '0;
   logic irUpdate;
   logic [LVL_W-1:0] fifoLevel;
   logic overflow;

   int checks = 0;
   int failures = 0;

   bmr_tdee_qsys_nios2_dbg_cmd_bridge_if #(.IR_W(IR_W), .DR_W(DR_W)) cmdIf ();

   bmr_tdee_qsys_nios2_dbg_cmd_bridge #(
      .IR_W(IR_W), .DR_W(DR_W), .DEPTH(DEPTH), .SYNC_STAGES(SYNC_STAGES), .ACTION_BIT(ACTION_BIT)
   ) dut (
      .clk          (clock),
      .reset        (reset),
      .vs_udr_i     (vsUdr),
      .vs_uir_i     (vsUir),
      .ir_in_i      (irIn),
      .sr_i         (srIn),
      .cmd          (cmdIf),
      .ir_update_o  (irUpdate),
      .fifo_level_o (fifoLevel),
      .overflow_o   (overflow),
      .ovf_clr_i    (ovfClr)
   );

   // Free-running system clock, posedges at 5, 15, 25 ...
   always #5 clock = ~clock;

   typedef struct packed {
      logic [IR_W-1:0] ir;
      logic [DR_W-1:0] data;
   } cmdEntry_t;

   cmdEntry_t modelQ[$];
   cmdEntry_t headEntry;
   int udrDue[$];
   int uirDue[$];
   int edgeNo = 0;
   bit prevUdr, prevUdrValid, prevUir, prevUirValid;
   bit udrEvent, uirEvent, pushDue, popNow, dropNow;
   logic [DR_W-1:0] expJdo = '0;
   logic [NUM_CMD-1:0] expAct = '0;
   logic [NUM_CMD-1:0] expNoAct = '0;
   bit expIrUpdate = 0;
   bit expOvf = 0;

   // Behavioural model: a 0->1 strobe sample at edge n (previous post-reset sample low) lands as a
   // push at edge n+SYNC_STAGES+1, or as an ir_update pulse after edge n+SYNC_STAGES
   always @(posedge clock) begin
      if (reset) begin
         modelQ.delete();
         udrDue.delete();
         uirDue.delete();
         prevUdrValid = 0;
         prevUirValid = 0;
         expJdo = '0;
         expAct = '0;
         expNoAct = '0;
         expIrUpdate = 0;
         expOvf = 0;
      end else begin
         udrEvent = vsUdr && prevUdrValid && !prevUdr;
         uirEvent = vsUir && prevUirValid && !prevUir;
         prevUdr = vsUdr;
         prevUir = vsUir;
         prevUdrValid = 1;
         prevUirValid = 1;
         if (udrEvent) udrDue.push_back(edgeNo + SYNC_STAGES + 1);
         if (uirEvent) uirDue.push_back(edgeNo + SYNC_STAGES);
         pushDue = (udrDue.size() > 0) && (udrDue[0] == edgeNo);
         if (pushDue) void'(udrDue.pop_front());
         expIrUpdate = (uirDue.size() > 0) && (uirDue[0] == edgeNo);
         if (expIrUpdate) void'(uirDue.pop_front());
         popNow = (modelQ.size() > 0) && cmdIf.cmd_ready;
         dropNow = pushDue && (modelQ.size() == DEPTH) && !popNow;
         expAct = '0;
         expNoAct = '0;
         if (popNow) begin
            headEntry = modelQ.pop_front();
            expJdo = headEntry.data;
            if (headEntry.data[ACTION_BIT]) expAct[headEntry.ir] = 1'b1;
            else expNoAct[headEntry.ir] = 1'b1;
         end
         if (pushDue && !dropNow) modelQ.push_back({irIn, srIn});
         if (dropNow) expOvf = 1;
         else if (ovfClr) expOvf = 0;
      end
      edgeNo++;
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Per-cycle comparison of every DUT output against the model, just after each active edge
   always @(posedge clock) begin
      #2;
      checkOutput("model_cmd_valid", 64'(cmdIf.cmd_valid), 64'(modelQ.size() != 0));
      checkOutput("model_fifo_level", 64'(fifoLevel), 64'(modelQ.size()));
      checkOutput("model_cmd_ir", 64'(cmdIf.cmd_ir), (modelQ.size() != 0) ? 64'(modelQ[0].ir) : 64'd0);
      checkOutput("model_jdo", 64'(cmdIf.jdo), 64'(expJdo));
      checkOutput("model_take_action", 64'(cmdIf.take_action), 64'(expAct));
      checkOutput("model_take_no_action", 64'(cmdIf.take_no_action), 64'(expNoAct));
      checkOutput("model_ir_update", 64'(irUpdate), 64'(expIrUpdate));
      checkOutput("model_overflow", 64'(overflow), 64'(expOvf));
   end

   logic [NUM_CMD-1:0] seenAct = '0;
   logic [NUM_CMD-1:0] seenNoAct = '0;
   int irUpdCount = 0;

   // Accumulates pulses between bench-controlled clears so directed checks can see them
   always @(negedge clock) begin
      seenAct = seenAct | cmdIf.take_action;
      seenNoAct = seenNoAct | cmdIf.take_no_action;
      if (irUpdate) irUpdCount++;
   end

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic applyStimulus(input logic [IR_W-1:0] ir, input logic [DR_W-1:0] data, input int highCycles);
      @(negedge clock);
      irIn = ir;
      srIn = data;
      vsUdr = 1'b1;
      repeat (highCycles) @(negedge clock);
      vsUdr = 1'b0;
      repeat (6) @(negedge clock);
   endtask

   // Directed sequences
   initial begin
      logic [DR_W-1:0] d;
      cmdIf.cmd_ready = 1'b0;
      waitCycles(3);
      reset = 1'b0;
      waitCycles(3);

      $display("[TB] single action command, latency and decode");
      cmdIf.cmd_ready = 1'b1;
      @(negedge clock);
      irIn = IR_BREAK;
      srIn = 38'h20_A5A5_A5A5;
      vsUdr = 1'b1;
      @(posedge clock); #2;
      @(posedge clock); #2;
      @(posedge clock); #2;
      checkOutput("lat_valid_E2", 64'(cmdIf.cmd_valid), 64'd0);
      @(negedge clock);
      vsUdr = 1'b0;
      @(posedge clock); #2;
      checkOutput("lat_valid_E3", 64'(cmdIf.cmd_valid), 64'd1);
      checkOutput("lat_cmd_ir_E3", 64'(cmdIf.cmd_ir), 64'd2);
      @(posedge clock); #2;
      checkOutput("act_pulse", 64'(cmdIf.take_action), 64'h4);
      checkOutput("act_no_action_zero", 64'(cmdIf.take_no_action), 64'h0);
      checkOutput("act_jdo", 64'(cmdIf.jdo), 64'h20_A5A5_A5A5);
      @(posedge clock); #2;
      checkOutput("act_pulse_ends", 64'(cmdIf.take_action), 64'h0);
      waitCycles(4);

      $display("[TB] single no-action command");
      seenAct = '0;
      seenNoAct = '0;
      applyStimulus(IR_TRACEMEM, 38'h2_A5A5_A5A5, 2);
      checkOutput("noact_seen", 64'(seenNoAct), 64'h2);
      checkOutput("noact_no_action", 64'(seenAct), 64'h0);
      checkOutput("noact_jdo", 64'(cmdIf.jdo), 64'h2_A5A5_A5A5);

      $display("[TB] five captures into a four-entry queue, then drain");
      cmdIf.cmd_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         d = 38'h10 + DR_W'(i);
         if (i % 2 == 0) d[ACTION_BIT] = 1'b1;
         applyStimulus(IR_W'(i), d, 2);
      end
      checkOutput("ovf_level_full", 64'(fifoLevel), 64'd4);
      checkOutput("ovf_set", 64'(overflow), 64'd1);
      seenAct = '0;
      seenNoAct = '0;
      @(negedge clock);
      cmdIf.cmd_ready = 1'b1;
      waitCycles(6);
      cmdIf.cmd_ready = 1'b0;
      checkOutput("drain_level", 64'(fifoLevel), 64'd0);
      checkOutput("drain_act_seen", 64'(seenAct), 64'h5);
      checkOutput("drain_noact_seen", 64'(seenNoAct), 64'hA);
      checkOutput("drain_last_jdo", 64'(cmdIf.jdo), 64'h13);
      checkOutput("drain_ovf_sticky", 64'(overflow), 64'd1);
      ovfClr = 1'b1;
      @(negedge clock);
      ovfClr = 1'b0;
      @(negedge clock);
      checkOutput("ovf_cleared", 64'(overflow), 64'd0);

      $display("[TB] simultaneous push and pop at full");
      for (int i = 0; i < 4; i++) begin
         applyStimulus(IR_W'(3 - i), 38'h20_0000_0050 + DR_W'(i), 2);
      end
      checkOutput("full_level", 64'(fifoLevel), 64'd4);
      @(negedge clock);
      irIn = IR_TRACEMEM;
      srIn = 38'h20_0000_00AA;
      vsUdr = 1'b1;
      @(negedge clock);
      @(negedge clock);
      @(negedge clock);
      cmdIf.cmd_ready = 1'b1;
      vsUdr = 1'b0;
      @(posedge clock); #2;
      checkOutput("pushpop_level", 64'(fifoLevel), 64'd4);
      checkOutput("pushpop_no_ovf", 64'(overflow), 64'd0);
      @(negedge clock);
      cmdIf.cmd_ready = 1'b0;
      waitCycles(2);
      cmdIf.cmd_ready = 1'b1;
      waitCycles(8);
      cmdIf.cmd_ready = 1'b0;
      checkOutput("pushpop_drained", 64'(fifoLevel), 64'd0);
      checkOutput("pushpop_last_jdo", 64'(cmdIf.jdo), 64'h20_0000_00AA);

      $display("[TB] update-IR pulse and long update-DR strobe");
      irUpdCount = 0;
      @(negedge clock);
      vsUir = 1'b1;
      waitCycles(3);
      vsUir = 1'b0;
      waitCycles(6);
      checkOutput("uir_pulse_count", 64'(irUpdCount), 64'd1);
      checkOutput("uir_level_unchanged", 64'(fifoLevel), 64'd0);
      applyStimulus(IR_OCIMEM, 38'h3F, 20);
      checkOutput("long_udr_one_push", 64'(fifoLevel), 64'd1);

      $display("[TB] reset with queued entries and strobe held high");
      applyStimulus(IR_BREAK, 38'h61, 2);
      applyStimulus(IR_TRACECTRL, 38'h62, 2);
      checkOutput("pre_reset_level", 64'(fifoLevel), 64'd3);
      @(negedge clock);
      vsUdr = 1'b1;
      waitCycles(5);
      reset = 1'b1;
      #1;
      checkOutput("rst_valid", 64'(cmdIf.cmd_valid), 64'd0);
      checkOutput("rst_level", 64'(fifoLevel), 64'd0);
      checkOutput("rst_cmd_ir", 64'(cmdIf.cmd_ir), 64'd0);
      checkOutput("rst_jdo", 64'(cmdIf.jdo), 64'd0);
      checkOutput("rst_pulses", 64'({cmdIf.take_action, cmdIf.take_no_action, irUpdate, overflow}), 64'd0);
      waitCycles(3);
      reset = 1'b0;
      waitCycles(10);
      checkOutput("post_rst_no_push", 64'(fifoLevel), 64'd0);
      vsUdr = 1'b0;
      waitCycles(4);
      vsUdr = 1'b1;
      waitCycles(6);
      checkOutput("post_rst_new_rise", 64'(fifoLevel), 64'd1);
      vsUdr = 1'b0;
      waitCycles(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
